// File: rtl/fp_add_align_if.sv
// fp_add_align_if -- operand/result bundle for the FP adder alignment stage.
//
// Upstream side : in_valid, in_ready, in_a, in_b (IEEE-754 packed operands)
// Downstream    : out_valid, out_ready, out_sign, out_sub, out_exp,
//                 out_man_l, out_man_s, out_flags
//
// Modports:
//   slave  - view taken by fp_add_align (consumes operands, produces results)
//   master - view taken by whatever feeds operands and sinks results
`timescale 1ns/1ps

interface fp_add_align_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 4;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;

    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic             out_sub;
    logic [EXP_W-1:0] out_exp;
    logic [MW-1:0]    out_man_l;
    logic [MW-1:0]    out_man_s;
    logic [2:0]       out_flags;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sign, out_sub, out_exp,
               out_man_l, out_man_s, out_flags
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sign, out_sub, out_exp,
               out_man_l, out_man_s, out_flags
    );
endinterface

// File: rtl/fp_add_align.sv
// fp_add_align -- operand-alignment stage of the single-precision FP adder.
//
// Unpacks two IEEE-754 operands, orders them by magnitude and right-shifts the
// smaller mantissa (with guard/round/sticky) so the downstream mantissa adder
// sees both operands on a common exponent. Two-stage valid/ready pipeline:
//   S1: unpack, order, exponent difference
//   S2: alignment shift with sticky collection
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset; clears both stages and all outputs
//   bus    - fp_add_align_if.slave: operand handshake in, aligned result out
//            (out_man_l = {hidden,frac,3'b000}, out_man_s = shifted smaller
//            mantissa with sticky in bit 0, out_flags = {nan,inf,inf_sub})
//
// Build option:
//   FP_ALIGN_SPECIAL_EN - when defined, S1 decodes all-ones exponents into the
//   NaN/Inf flags carried alongside the data. When undefined, all-ones
//   exponents are ordinary values and out_flags is held at 0.
`timescale 1ns/1ps

module fp_add_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_add_align_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 4;
    localparam int KW = EXP_W + 1 + MAN_W;

    // ------------------------------------------------------------------
    // Handshake / stage advance
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_load;
    logic s1_load;
    logic in_fire;
    logic s1_move;

    assign s2_load  = !s2_valid || bus.out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_fire  = bus.in_valid && s1_load;
    assign s1_move  = s1_valid && s2_load;

    assign bus.in_ready = s1_load;

    // ------------------------------------------------------------------
    // S1 combinational: unpack and order
    // ------------------------------------------------------------------
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] frac_a;
    logic [MAN_W-1:0] frac_b;
    logic             hid_a;
    logic             hid_b;
    logic [EXP_W-1:0] eexp_a;
    logic [EXP_W-1:0] eexp_b;
    logic [KW-1:0]    key_a;
    logic [KW-1:0]    key_b;
    logic             a_large;

    logic             s1_sign_d;
    logic             s1_sub_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [EXP_W-1:0] s1_diff_d;
    logic [MW-1:0]    s1_man_l_d;
    logic [MW-1:0]    s1_man_s_d;
    logic [2:0]       s1_flags_d;

    always_comb begin
        sign_a = bus.in_a[W-1];
        sign_b = bus.in_b[W-1];
        exp_a  = bus.in_a[W-2:MAN_W];
        exp_b  = bus.in_b[W-2:MAN_W];
        frac_a = bus.in_a[MAN_W-1:0];
        frac_b = bus.in_b[MAN_W-1:0];

        // Denormals (and zero) carry no hidden bit and sit at effective exponent 1.
        hid_a  = |exp_a;
        hid_b  = |exp_b;
        eexp_a = hid_a ? exp_a : EXP_W'(1);
        eexp_b = hid_b ? exp_b : EXP_W'(1);

        // Magnitude key; a tie keeps A as the large operand.
        key_a   = {eexp_a, hid_a, frac_a};
        key_b   = {eexp_b, hid_b, frac_b};
        a_large = (key_a >= key_b);

        s1_sub_d = sign_a ^ sign_b;
        if (a_large) begin
            s1_sign_d  = sign_a;
            s1_exp_d   = eexp_a;
            s1_diff_d  = eexp_a - eexp_b;
            s1_man_l_d = {hid_a, frac_a, 3'b000};
            s1_man_s_d = {hid_b, frac_b, 3'b000};
        end else begin
            s1_sign_d  = sign_b;
            s1_exp_d   = eexp_b;
            s1_diff_d  = eexp_b - eexp_a;
            s1_man_l_d = {hid_b, frac_b, 3'b000};
            s1_man_s_d = {hid_a, frac_a, 3'b000};
        end
    end

`ifdef FP_ALIGN_SPECIAL_EN
    logic max_a;
    logic max_b;
    logic nan_a;
    logic nan_b;
    logic inf_a;
    logic inf_b;
    logic any_nan;

    always_comb begin
        max_a   = &exp_a;
        max_b   = &exp_b;
        nan_a   = max_a && (|frac_a);
        nan_b   = max_b && (|frac_b);
        inf_a   = max_a && !(|frac_a);
        inf_b   = max_b && !(|frac_b);
        any_nan = nan_a || nan_b;
        s1_flags_d = {any_nan,
                      (inf_a || inf_b) && !any_nan,
                      inf_a && inf_b && (sign_a ^ sign_b)};
    end
`else
    assign s1_flags_d = 3'b000;
`endif

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic             s1_sign;
    logic             s1_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [EXP_W-1:0] s1_diff;
    logic [MW-1:0]    s1_man_l;
    logic [MW-1:0]    s1_man_s;
    logic [2:0]       s1_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_diff  <= '0;
            s1_man_l <= '0;
            s1_man_s <= '0;
            s1_flags <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                s1_sign  <= s1_sign_d;
                s1_sub   <= s1_sub_d;
                s1_exp   <= s1_exp_d;
                s1_diff  <= s1_diff_d;
                s1_man_l <= s1_man_l_d;
                s1_man_s <= s1_man_s_d;
                s1_flags <= s1_flags_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: alignment shift with sticky
    // ------------------------------------------------------------------
    logic [31:0]   diff_wide;
    logic          lost;
    logic [MW-1:0] man_s_sh;

    always_comb begin
        diff_wide = 32'(s1_diff);
        lost      = 1'b0;
        man_s_sh  = '0;
        // Any bit at a position below the shift amount falls off the end.
        for (int unsigned i = 0; i < 32'(MW); i++) begin
            if (i < diff_wide) begin
                lost = lost | s1_man_s[i];
            end
        end
        if (diff_wide >= 32'(MW)) begin
            man_s_sh = {{(MW-1){1'b0}}, |s1_man_s};
        end else begin
            man_s_sh    = s1_man_s >> s1_diff;
            man_s_sh[0] = man_s_sh[0] | lost;
        end
    end

    // ------------------------------------------------------------------
    // S2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic             s2_sign;
    logic             s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [MW-1:0]    s2_man_l;
    logic [MW-1:0]    s2_man_s;
    logic [2:0]       s2_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_man_l <= '0;
            s2_man_s <= '0;
            s2_flags <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s1_move) begin
                s2_sign  <= s1_sign;
                s2_sub   <= s1_sub;
                s2_exp   <= s1_exp;
                s2_man_l <= s1_man_l;
                s2_man_s <= man_s_sh;
                s2_flags <= s1_flags;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sign  = s2_sign;
    assign bus.out_sub   = s2_sub;
    assign bus.out_exp   = s2_exp;
    assign bus.out_man_l = s2_man_l;
    assign bus.out_man_s = s2_man_s;
    assign bus.out_flags = s2_flags;

endmodule
